pb_fill_engine: RTL
===================

PB_FILL_ENGINE -- requirements
Module: pb_fill_engine

Interface
REQ-001 Parameter FB_W, default 160, framebuffer width in pixels.
REQ-002 Parameter FB_H, default 120, framebuffer height in pixels.
REQ-003 Parameter AW, default 15, pixel-buffer write-address width.
REQ-004 Parameter DW, default 4, pixel data width.
REQ-005 clk_clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-006 reset_reset_n  in  1  synchronous, active-low reset.
REQ-007 cmd_valid  in  1  command present.
REQ-008 cmd_ready  out  1  engine can accept a command.
REQ-009 cmd_x0 / cmd_x1  in  8 each  inclusive rectangle column bounds.
REQ-010 cmd_y0 / cmd_y1  in  7 each  inclusive rectangle row bounds.
REQ-011 cmd_color  in  DW  fill colour.
REQ-012 PB_WA  out  AW  pixel-buffer write address, y*FB_W + x.
REQ-013 PB_DATA  out  DW  pixel-buffer write data.
REQ-014 PB_WE  out  1  pixel-buffer write enable, one pixel per asserted cycle.
REQ-015 busy  out  1  high from command acceptance until done.
REQ-016 done  out  1  single-cycle pulse at command completion.

Function
REQ-017 States SHALL be IDLE, CLIP, FILL, DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; the handshake completes when cmd_valid and cmd_ready are both high on a clock edge; all cmd_* fields SHALL be registered then.
REQ-019 IDLE -> CLIP on handshake; CLIP -> FILL if rectangle non-empty, else CLIP -> DONE; FILL -> DONE after the last pixel write; DONE -> IDLE unconditionally.
REQ-020 CLIP SHALL clamp x1 to FB_W-1 and y1 to FB_H-1; the rectangle is empty if x0 > clamped x1, y0 > clamped y1, x0 >= FB_W, or y0 >= FB_H.
REQ-021 FILL SHALL assert PB_WE every cycle, row-major: x from x0 to x1, then y+1, x back to x0; first write in the cycle after CLIP.
REQ-022 Write count SHALL be exactly (x1-x0+1)*(y1-y0+1) after clamping; empty rectangle gives zero writes.
REQ-023 Row base address SHALL be accumulated (+FB_W per row), not multiplied; PB_WA SHALL never exceed FB_W*FB_H-1.
REQ-024 PB_DATA SHALL equal the registered cmd_color whenever PB_WE is high; PB_WA and PB_DATA SHALL be don't-care while PB_WE is low.
REQ-025 done SHALL be high for exactly the DONE cycle; busy SHALL be high in CLIP, FILL and DONE.
REQ-026 Changes on cmd_* while busy SHALL have no effect; cmd_valid held high through DONE SHALL be accepted on the first IDLE cycle.
REQ-027 Latency: handshake at edge N -> first PB_WE at cycle N+2; done one cycle after the last PB_WE.

Reset
REQ-028 reset_reset_n low on a clock edge SHALL force IDLE and PB_WE=0, done=0, busy=0, cmd_ready=1, PB_WA=0, PB_DATA=0 from the next cycle.
REQ-029 Reset during FILL SHALL abandon the fill with no further writes and no done pulse.

Configuration
REQ-030 Macro PB_FILL_CLEAR_EN defined: adds input cmd_clear (1 bit); a handshake with cmd_clear=1 SHALL ignore coordinates and fill addresses 0..FB_W*FB_H-1 in order.
REQ-031 Macro PB_FILL_CLEAR_EN undefined: cmd_clear port and logic SHALL be absent; behaviour otherwise identical.

Verification
REQ-032 Single pixel x0=x1=5, y0=y1=2, colour 0xA -> one PB_WE, PB_WA=325, PB_DATA=0xA, done pulse one cycle later.
REQ-033 Rectangle x 158..170, y 118..125, colour 0x3 -> clamped to 158..159 x 118..119; 4 writes at 19038, 19039, 19198, 19199.
REQ-034 Inverted x0=10, x1=4 -> zero PB_WE, done in the cycle after CLIP, cmd_ready back high next cycle.
REQ-035 Reset asserted on the 3rd write of a 4x4 fill -> no PB_WE after reset edge, no done, cmd_ready=1.
REQ-036 Back-to-back: cmd_valid held high for two commands -> second accepted on first IDLE cycle after DONE, no writes lost or duplicated.
REQ-037 With PB_FILL_CLEAR_EN, cmd_clear=1, colour 0x0 -> 19200 writes, addresses 0..19199 contiguous, single done pulse.

Source files
------------

// File: rtl/pb_fill_engine.sv
// rtl/pb_fill_engine.sv - rectangle fill engine writing a colour into a pixel buffer
//
// Purpose: accepts one rectangle command at a time, clips it to the
// framebuffer and writes one pixel per cycle in row-major order.
// Optional feature macro: PB_FILL_CLEAR_EN (adds cmd_clear, whole-buffer fill).
//
// Ports:
//   clk_clk                        rising-edge clock
//   reset_reset_n                  synchronous active-low reset
//   cmd_valid / cmd_ready          command handshake
//   cmd_x0, cmd_x1                 inclusive column bounds (8 bit)
//   cmd_y0, cmd_y1                 inclusive row bounds (7 bit)
//   cmd_color                      fill colour
//   cmd_clear                      (PB_FILL_CLEAR_EN only) fill entire buffer
//   PB_WA, PB_DATA, PB_WE          pixel-buffer write port
//   busy                           command in progress
//   done                           one-cycle completion pulse
module pb_fill_engine #(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int AW   = 15,
  parameter int DW   = 4
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_x0,
  input  logic [7:0]    cmd_x1,
  input  logic [6:0]    cmd_y0,
  input  logic [6:0]    cmd_y1,
  input  logic [DW-1:0] cmd_color,
`ifdef PB_FILL_CLEAR_EN
  input  logic          cmd_clear,
`endif
  output logic [AW-1:0] PB_WA,
  output logic [DW-1:0] PB_DATA,
  output logic          PB_WE,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

  localparam logic [7:0]    X_MAX  = 8'(FB_W - 1);
  localparam logic [6:0]    Y_MAX  = 7'(FB_H - 1);
  localparam logic [AW-1:0] FB_W_A = AW'(FB_W);

  state_t state, state_nxt;

  logic [7:0]    x0_r, x1_r, x_cur;
  logic [6:0]    y0_r, y1_r, y_cur;
  logic [AW-1:0] row_base;
  logic [DW-1:0] color_r;
`ifdef PB_FILL_CLEAR_EN
  logic          clear_r;
`endif

  logic [7:0] x1_clamp;
  logic [6:0] y1_clamp;
  logic       rect_empty;
  logic       last_pixel;

  // x0 >= FB_W and y0 >= FB_H are written as "> max" to stay in the field widths.
  always_comb begin
    x1_clamp   = (x1_r > X_MAX) ? X_MAX : x1_r;
    y1_clamp   = (y1_r > Y_MAX) ? Y_MAX : y1_r;
    rect_empty = (x0_r > x1_clamp) || (y0_r > y1_clamp) ||
                 (x0_r > X_MAX) || (y0_r > Y_MAX);
`ifdef PB_FILL_CLEAR_EN
    if (clear_r) rect_empty = 1'b0;
`endif
    last_pixel = (x_cur == x1_r) && (y_cur == y1_r);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = CLIP;
      CLIP:    state_nxt = rect_empty ? DONE : FILL;
      FILL:    if (last_pixel) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    PB_WE     = (state == FILL);
    PB_WA     = row_base + AW'(x_cur);
    PB_DATA   = color_r;
  end

  // Command registers and fill counters. After CLIP, x1_r/y1_r hold the
  // clamped bounds so the FILL loop compares against final limits only.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      x0_r     <= '0;
      x1_r     <= '0;
      y0_r     <= '0;
      y1_r     <= '0;
      x_cur    <= '0;
      y_cur    <= '0;
      row_base <= '0;
      color_r  <= '0;
`ifdef PB_FILL_CLEAR_EN
      clear_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x0_r    <= cmd_x0;
            x1_r    <= cmd_x1;
            y0_r    <= cmd_y0;
            y1_r    <= cmd_y1;
            color_r <= cmd_color;
`ifdef PB_FILL_CLEAR_EN
            clear_r <= cmd_clear;
`endif
          end
        end
        CLIP: begin
          x1_r     <= x1_clamp;
          y1_r     <= y1_clamp;
          x_cur    <= x0_r;
          y_cur    <= y0_r;
          // Starting row offset is a constant-coefficient product; every
          // subsequent row is reached by adding FB_W.
          row_base <= AW'(y0_r) * FB_W_A;
`ifdef PB_FILL_CLEAR_EN
          if (clear_r) begin
            x0_r     <= '0;
            x1_r     <= X_MAX;
            y1_r     <= Y_MAX;
            x_cur    <= '0;
            y_cur    <= '0;
            row_base <= '0;
          end
`endif
        end
        FILL: begin
          if (x_cur == x1_r) begin
            x_cur <= x0_r;
            if (y_cur != y1_r) begin
              y_cur    <= y_cur + 7'd1;
              row_base <= row_base + FB_W_A;
            end
          end else begin
            x_cur <= x_cur + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
